// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg
//   Shared types and constants for the register-file write-back path.
//   REG_ADDR_W / DATA_W : register address and data widths
//   REG_ZERO            : hard-wired zero register address
//   wb_req_t            : one pending register write {rd, data}
//   wb_src_t            : which source drives the write port next cycle
package regfile_writeback_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MD   = 2'd2
   } wb_src_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if
//   Valid/ready handshake carrying multdiv results into the write-back block.
//   md_valid : result offered (held with md_rd/md_data until transfer)
//   md_ready : write-back buffer can accept a result
//   md_rd    : destination register of the result
//   md_data  : result value
//   master   : multdiv unit side;  slave : write-back side
interface regfile_writeback_if
   import regfile_writeback_pkg::*;
   ();

   logic                  md_valid;
   logic                  md_ready;
   logic [REG_ADDR_W-1:0] md_rd;
   logic [DATA_W-1:0]     md_data;

   modport master (
      output md_valid,
      output md_rd,
      output md_data,
      input  md_ready
   );

   modport slave (
      input  md_valid,
      input  md_rd,
      input  md_data,
      output md_ready
   );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo
//   Parameterised-depth FIFO of wb_req_t with simultaneous push/pop.
//   DEPTH     : entries (power of two, >= 2)
//   clock     : rising-edge clock
//   ctrlReset : asynchronous active-high reset, empties the FIFO
//   push/pushData : enqueue (ignored when full)
//   pop           : dequeue head (ignored when empty)
//   headData  : current head entry (valid when !empty)
//   full/empty: occupancy flags
module wb_fifo
   import regfile_writeback_pkg::*;
   #(
      parameter int unsigned DEPTH = 2
   ) (
      input  logic    clock,
      input  logic    ctrlReset,
      input  logic    push,
      input  wb_req_t pushData,
      input  logic    pop,
      output wb_req_t headData,
      output logic    full,
      output logic    empty
   );

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_req_t            mem [DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic [CNT_W-1:0]   count;
   logic               doPush;
   logic               doPop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign doPush   = push && !full;
   assign doPop    = pop && !empty;
   assign headData = mem[rdPtr];

   always_ff @(posedge clock or posedge ctrlReset) begin
      if (ctrlReset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         count <= count + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   // Storage needs no reset: occupancy is tracked by count alone.
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Drives the register file write port. Merges single-cycle ALU results with
//   buffered multdiv results (ALU has priority) and keeps a per-register busy
//   scoreboard for operands still pending from multdiv.
//   Optional feature macro: REGFILE_BYPASS_EN (adds fwd_* / fwd_data_* ports).
//   Ports:
//     clock, ctrl_reset          : clock, async active-high reset
//     alu_we/alu_rd/alu_data     : ALU result (always accepted)
//     md_issue/md_issue_rd       : multdiv op issued, its destination
//     md (slave modport)         : multdiv result valid/ready handshake
//     rd_addr_a/b, busy_a/b      : decode read addresses and pending flags
//     ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered write port
//     fwd_a/b, fwd_data_a/b      : bypass of the in-flight write (macro only)
module regfile_writeback
   import regfile_writeback_pkg::*;
   #(
      parameter int unsigned MD_BUF_DEPTH = 2
   ) (
      input  logic                  clock,
      input  logic                  ctrl_reset,
      input  logic                  alu_we,
      input  logic [REG_ADDR_W-1:0] alu_rd,
      input  logic [DATA_W-1:0]     alu_data,
      input  logic                  md_issue,
      input  logic [REG_ADDR_W-1:0] md_issue_rd,
      regfile_writeback_if.slave    md,
      input  logic [REG_ADDR_W-1:0] rd_addr_a,
      input  logic [REG_ADDR_W-1:0] rd_addr_b,
      output logic                  busy_a,
      output logic                  busy_b,
      output logic                  ctrl_writeEnable,
      output logic [REG_ADDR_W-1:0] ctrl_writeReg,
      output logic [DATA_W-1:0]     data_writeReg
`ifdef REGFILE_BYPASS_EN
      ,
      output logic                  fwd_a,
      output logic                  fwd_b,
      output logic [DATA_W-1:0]     fwd_data_a,
      output logic [DATA_W-1:0]     fwd_data_b
`endif
   );

   logic                bufFull;
   logic                bufEmpty;
   logic                bufPush;
   logic                bufPop;
   wb_req_t             bufHead;
   wb_req_t             bufIn;
   wb_src_t             wbSrc;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busyNext;

   // Results to r0 still complete the handshake but are never enqueued.
   assign md.md_ready = !bufFull;
   assign bufPush     = md.md_valid && !bufFull && (md.md_rd != REG_ZERO);
   assign bufIn       = '{rd: md.md_rd, data: md.md_data};
   assign bufPop      = (wbSrc == SRC_MD);

   wb_fifo #(
      .DEPTH (MD_BUF_DEPTH)
   ) u_mdBuf (
      .clock     (clock),
      .ctrlReset (ctrl_reset),
      .push      (bufPush),
      .pushData  (bufIn),
      .pop       (bufPop),
      .headData  (bufHead),
      .full      (bufFull),
      .empty     (bufEmpty)
   );

   always_comb begin
      wbSrc = SRC_NONE;
      if (alu_we && (alu_rd != REG_ZERO)) wbSrc = SRC_ALU;
      else if (!bufEmpty)                 wbSrc = SRC_MD;
   end

   // Clear first so a same-cycle set on the same register wins.
   always_comb begin
      busyNext = busy;
      if (bufPop) busyNext[bufHead.rd] = 1'b0;
      if (md_issue && (md_issue_rd != REG_ZERO)) busyNext[md_issue_rd] = 1'b1;
      busyNext[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
         busy             <= '0;
      end else begin
         busy <= busyNext;
         unique case (wbSrc)
            SRC_ALU: begin
               ctrl_writeEnable <= 1'b1;
               ctrl_writeReg    <= alu_rd;
               data_writeReg    <= alu_data;
            end
            SRC_MD: begin
               ctrl_writeEnable <= 1'b1;
               ctrl_writeReg    <= bufHead.rd;
               data_writeReg    <= bufHead.data;
            end
            default: ctrl_writeEnable <= 1'b0;
         endcase
      end
   end

   assign busy_a = busy[rd_addr_a];
   assign busy_b = busy[rd_addr_b];

`ifdef REGFILE_BYPASS_EN
   assign fwd_a      = ctrl_writeEnable && (ctrl_writeReg == rd_addr_a) && (rd_addr_a != REG_ZERO);
   assign fwd_b      = ctrl_writeEnable && (ctrl_writeReg == rd_addr_b) && (rd_addr_b != REG_ZERO);
   assign fwd_data_a = data_writeReg;
   assign fwd_data_b = data_writeReg;
`endif

   // Only one multdiv op may be outstanding at a time.
   mdIssueSingle: assert property (@(posedge clock) disable iff (ctrl_reset)
      md_issue |-> (busy == '0));

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback
//   Directed testbench for regfile_writeback. Inputs are driven 1 time unit
//   after the rising edge; outputs are checked at the same offset, so each
//   check sees the state loaded by the preceding edge.
module tb_regfile_writeback;
   import regfile_writeback_pkg::*;

   logic                  clock = 1'b0;
   logic                  ctrl_reset;
   logic                  alu_we;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0]     alu_data;
   logic                  md_issue;
   logic [REG_ADDR_W-1:0] md_issue_rd;
   logic [REG_ADDR_W-1:0] rd_addr_a;
   logic [REG_ADDR_W-1:0] rd_addr_b;
   logic                  busy_a;
   logic                  busy_b;
   logic                  ctrl_writeEnable;
   logic [REG_ADDR_W-1:0] ctrl_writeReg;
   logic [DATA_W-1:0]     data_writeReg;
`ifdef REGFILE_BYPASS_EN
   logic                  fwd_a;
   logic                  fwd_b;
   logic [DATA_W-1:0]     fwd_data_a;
   logic [DATA_W-1:0]     fwd_data_b;
`endif

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   regfile_writeback_if mdIf ();

   regfile_writeback #(
      .MD_BUF_DEPTH (2)
   ) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .alu_we           (alu_we),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .md_issue         (md_issue),
      .md_issue_rd      (md_issue_rd),
      .md               (mdIf.slave),
      .rd_addr_a        (rd_addr_a),
      .rd_addr_b        (rd_addr_b),
      .busy_a           (busy_a),
      .busy_b           (busy_b),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg)
`ifdef REGFILE_BYPASS_EN
      ,
      .fwd_a            (fwd_a),
      .fwd_b            (fwd_b),
      .fwd_data_a       (fwd_data_a),
      .fwd_data_b       (fwd_data_b)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idleInputs();
      alu_we         = 1'b0;
      alu_rd         = '0;
      alu_data       = '0;
      md_issue       = 1'b0;
      md_issue_rd    = '0;
      mdIf.md_valid  = 1'b0;
      mdIf.md_rd     = '0;
      mdIf.md_data   = '0;
   endtask

   task automatic test_reset();
      ctrl_reset = 1'b1;
      idleInputs();
      rd_addr_a = 5'd9;
      rd_addr_b = 5'd0;
      tick();
      tick();
      vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %0h want 0", ctrl_writeEnable); end
      vectors++; if (ctrl_writeReg !== 5'd0) begin miscompares++; $display("FAIL reset_reg: got %0h want 0", ctrl_writeReg); end
      vectors++; if (data_writeReg !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %0h want 0", data_writeReg); end
      vectors++; if (mdIf.md_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0h want 1", mdIf.md_ready); end
      vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy_a: got %0h want 0", busy_a); end
`ifdef REGFILE_BYPASS_EN
      vectors++; if (fwd_a !== 1'b0 || fwd_b !== 1'b0) begin miscompares++; $display("FAIL reset_fwd: got %0h%0h want 00", fwd_a, fwd_b); end
`endif
      #2 ctrl_reset = 1'b0;
      tick();
   endtask

   task automatic test_alu_write();
      alu_we = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      alu_we = 1'b0;
      vectors++; if (ctrl_writeEnable !== 1'b1) begin miscompares++; $display("FAIL alu_we: got %0h want 1", ctrl_writeEnable); end
      vectors++; if (ctrl_writeReg !== 5'd5) begin miscompares++; $display("FAIL alu_reg: got %0h want 5", ctrl_writeReg); end
      vectors++; if (data_writeReg !== 32'hDEADBEEF) begin miscompares++; $display("FAIL alu_data: got %0h want deadbeef", data_writeReg); end
      tick();
      vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL alu_we_drop: got %0h want 0", ctrl_writeEnable); end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 4; i++) begin
         alu_we = 1'b1; alu_rd = 5'(i + 16); alu_data = 32'h0101_0000 + 32'(i);
         tick();
         vectors++;
         if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'(i + 16) || data_writeReg !== 32'h0101_0000 + 32'(i)) begin
            miscompares++;
            $display("FAIL b2b_%0d: got we=%0h reg=%0h data=%0h want 1/%0h/%0h", i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, i + 16, 32'h0101_0000 + 32'(i));
         end
      end
      alu_we = 1'b0;
      tick();
   endtask

   task automatic test_md_collision();
      rd_addr_a = 5'd9;
      md_issue = 1'b1; md_issue_rd = 5'd9;
      tick();
      md_issue = 1'b0;
      vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL coll_busy_set: got %0h want 1", busy_a); end
      mdIf.md_valid = 1'b1; mdIf.md_rd = 5'd9; mdIf.md_data = 32'h12345678;
      for (int c = 1; c <= 3; c++) begin
         alu_we = 1'b1; alu_rd = 5'(c); alu_data = 32'hA000_0000 + 32'(c);
         tick();
         mdIf.md_valid = 1'b0;
         vectors++;
         if (ctrl_writeReg !== 5'(c) || ctrl_writeEnable !== 1'b1 || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_alu_%0d: got we=%0h reg=%0h busy=%0h want 1/%0h/1", c, ctrl_writeEnable, ctrl_writeReg, busy_a, c);
         end
      end
      alu_we = 1'b0;
      tick();
      vectors++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h12345678) begin
         miscompares++;
         $display("FAIL coll_md_write: got we=%0h reg=%0h data=%0h want 1/9/12345678", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL coll_busy_clr: got %0h want 0", busy_a); end
      tick();
      vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL coll_idle: got %0h want 0", ctrl_writeEnable); end
   endtask

   task automatic test_fill();
      alu_we = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020_2020;
      mdIf.md_valid = 1'b1; mdIf.md_rd = 5'd11; mdIf.md_data = 32'h0000_000A;
      tick();
      vectors++; if (mdIf.md_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready1: got %0h want 1", mdIf.md_ready); end
      mdIf.md_rd = 5'd12; mdIf.md_data = 32'h0000_000B;
      tick();
      vectors++; if (mdIf.md_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full: got %0h want 0", mdIf.md_ready); end
      mdIf.md_rd = 5'd13; mdIf.md_data = 32'h0000_000C;
      tick();
      vectors++; if (mdIf.md_ready !== 1'b0 || ctrl_writeReg !== 5'd20) begin miscompares++; $display("FAIL fill_hold: got ready=%0h reg=%0h want 0/14", mdIf.md_ready, ctrl_writeReg); end
      alu_we = 1'b0;
      tick();
      vectors++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd11 || data_writeReg !== 32'h0000_000A || mdIf.md_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_pop1: got we=%0h reg=%0h data=%0h ready=%0h want 1/b/a/1", ctrl_writeEnable, ctrl_writeReg, data_writeReg, mdIf.md_ready);
      end
      tick();
      mdIf.md_valid = 1'b0;
      vectors++;
      if (ctrl_writeReg !== 5'd12 || data_writeReg !== 32'h0000_000B || mdIf.md_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_pop2: got reg=%0h data=%0h ready=%0h want c/b/1", ctrl_writeReg, data_writeReg, mdIf.md_ready);
      end
      tick();
      vectors++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd13 || data_writeReg !== 32'h0000_000C) begin
         miscompares++;
         $display("FAIL fill_pop3: got we=%0h reg=%0h data=%0h want 1/d/c", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      tick();
      vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL fill_drain: got %0h want 0", ctrl_writeEnable); end
   endtask

   task automatic test_reg_zero();
      rd_addr_a = 5'd0; rd_addr_b = 5'd0;
      alu_we = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
      md_issue = 1'b1; md_issue_rd = 5'd0;
      mdIf.md_valid = 1'b1; mdIf.md_rd = 5'd0; mdIf.md_data = 32'h5555_5555;
      tick();
      idleInputs();
      vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL zero_we: got %0h want 0", ctrl_writeEnable); end
      vectors++; if (mdIf.md_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready: got %0h want 1", mdIf.md_ready); end
      vectors++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %0h%0h want 00", busy_a, busy_b); end
      tick();
      vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL zero_no_enq: got %0h want 0", ctrl_writeEnable); end
   endtask

   task automatic test_reset_mid();
      rd_addr_a = 5'd9;
      md_issue = 1'b1; md_issue_rd = 5'd9;
      tick();
      md_issue = 1'b0;
      alu_we = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444_4444;
      mdIf.md_valid = 1'b1; mdIf.md_rd = 5'd9; mdIf.md_data = 32'h0000_0099;
      tick();
      mdIf.md_rd = 5'd10; mdIf.md_data = 32'h0000_1010;
      tick();
      mdIf.md_valid = 1'b0;
      vectors++;
      if (mdIf.md_ready !== 1'b0 || busy_a !== 1'b1 || ctrl_writeEnable !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_pre: got ready=%0h busy=%0h we=%0h want 0/1/1", mdIf.md_ready, busy_a, ctrl_writeEnable);
      end
      #2 ctrl_reset = 1'b1;
      #1;
      vectors++;
      if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0 || busy_a !== 1'b0 || mdIf.md_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_async: got we=%0h reg=%0h data=%0h busy=%0h ready=%0h want 0/0/0/0/1", ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_a, mdIf.md_ready);
      end
      idleInputs();
      #2 ctrl_reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (ctrl_writeEnable !== 1'b0 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_stale_%0d: got we=%0h busy=%0h want 0/0", c, ctrl_writeEnable, busy_a);
         end
      end
   endtask

`ifdef REGFILE_BYPASS_EN
   task automatic test_bypass();
      rd_addr_a = 5'd3; rd_addr_b = 5'd7;
      alu_we = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5A5A5A5;
      tick();
      alu_we = 1'b0;
      vectors++; if (fwd_b !== 1'b1 || fwd_data_b !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL byp_hit: got fwd=%0h data=%0h want 1/a5a5a5a5", fwd_b, fwd_data_b); end
      vectors++; if (fwd_a !== 1'b0) begin miscompares++; $display("FAIL byp_miss_a: got %0h want 0", fwd_a); end
      rd_addr_b = 5'd0;
      #1;
      vectors++; if (fwd_b !== 1'b0) begin miscompares++; $display("FAIL byp_zero: got %0h want 0", fwd_b); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_alu_write();
      test_back_to_back();
      test_md_collision();
      test_fill();
      test_reg_zero();
      test_reset_mid();
`ifdef REGFILE_BYPASS_EN
      test_bypass();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
